wb_mem_arbiter: RTL and testbench

//  Sits between the SerV core and the SPI SRAM Wishbone slave. Merges the core's

---
 rtl/wb_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Merges the SerV instruction and data buses onto one registered Wishbone memory port,
// with a one-word instruction buffer in front of the slow SPI SRAM.
module wb_mem_arbiter #(
  parameter int unsigned AW      = 14,
  parameter bit          IBUF_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ibus_adr,
  input  logic          ibus_cyc,
  output logic [31:0]   ibus_rdt,
  output logic          ibus_ack,
  input  logic [31:0]   dbus_adr,
  input  logic [31:0]   dbus_dat,
  input  logic [3:0]    dbus_sel,
  input  logic          dbus_we,
  input  logic          dbus_cyc,
  output logic [31:0]   dbus_rdt,
  output logic          dbus_ack,
  output logic          mem_cyc,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [31:0]   mem_dat,
  output logic [3:0]    mem_sel,
  input  logic [31:0]   mem_rdt,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {StIdle, StHit, StMem, StResp} state_e;

  state_e          r_state, w_state_d;
  logic            r_last_dbus;  // owner of the current/most recent grant, 1 = dbus
  logic            r_mem_cyc, r_mem_we;
  logic [AW-1:0]   r_mem_adr;
  logic [31:0]     r_mem_dat, r_rdt;
  logic [3:0]      r_mem_sel;
  logic            r_ibuf_valid;
  logic [AW-1:0]   r_ibuf_tag;
  logic [31:0]     r_ibuf_data;

  logic            w_req, w_pick_dbus, w_hit;
  logic            w_unused_adr;

  assign w_unused_adr = ^{ibus_adr[31:AW+2], ibus_adr[1:0], dbus_adr[31:AW+2], dbus_adr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_req       = ibus_cyc | dbus_cyc;
    // Round-robin: with both requesting, the side that did not win last time goes next.
    w_pick_dbus = dbus_cyc & (~ibus_cyc | ~r_last_dbus);
    w_hit       = IBUF_EN & ~w_pick_dbus & r_ibuf_valid &
                  (r_ibuf_tag == ibus_adr[AW+1:2]);
    w_state_d   = r_state;
    unique case (r_state)
      StIdle:  if (w_req) w_state_d = w_hit ? StHit : StMem;
      StHit:   w_state_d = StIdle;
      StMem:   if (mem_ack) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    ibus_ack = ibus_cyc & ((r_state == StHit) | ((r_state == StResp) & ~r_last_dbus));
    dbus_ack = dbus_cyc & (r_state == StResp) & r_last_dbus;
    ibus_rdt = '0;
    if (ibus_ack) ibus_rdt = (r_state == StHit) ? r_ibuf_data : r_rdt;
    dbus_rdt = dbus_ack ? r_rdt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dbus  <= 1'b0;
      r_mem_cyc    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_dat    <= '0;
      r_mem_sel    <= '0;
      r_rdt        <= '0;
      r_ibuf_valid <= 1'b0;
      r_ibuf_tag   <= '0;
      r_ibuf_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_last_dbus <= w_pick_dbus;
            if (!w_hit) begin
              r_mem_cyc <= 1'b1;
              if (w_pick_dbus) begin
                r_mem_adr <= dbus_adr[AW+1:2];
                r_mem_we  <= dbus_we;
                r_mem_dat <= dbus_dat;
                r_mem_sel <= dbus_sel;
              end else begin
                r_mem_adr <= ibus_adr[AW+1:2];
                r_mem_we  <= 1'b0;
                r_mem_dat <= '0;
                r_mem_sel <= 4'hF;
              end
            end
          end
        end
        StMem: begin
          if (mem_ack) begin
            r_mem_cyc <= 1'b0;
            r_rdt     <= mem_rdt;
            // Partial writes also invalidate: the buffer holds whole words only.
            if (r_last_dbus && r_mem_we && (r_mem_adr == r_ibuf_tag)) r_ibuf_valid <= 1'b0;
          end
        end
        StResp: begin
          if (!r_last_dbus && IBUF_EN) begin
            r_ibuf_tag   <= r_mem_adr;
            r_ibuf_data  <= r_rdt;
            r_ibuf_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_cyc = r_mem_cyc;
  assign mem_adr = r_mem_adr;
  assign mem_we  = r_mem_we;
  assign mem_dat = r_mem_dat;
  assign mem_sel = r_mem_sel;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: vector table of single transactions plus hand sequences for
// round-robin, reset mid-access, aborted requests and a buffer-disabled instance.
module tb_wb_mem_arbiter;
  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ibus_adr = '0, ibus_rdt, dbus_adr = '0, dbus_dat = '0, dbus_rdt;
  logic        ibus_cyc = 1'b0, ibus_ack, dbus_we = 1'b0, dbus_cyc = 1'b0, dbus_ack;
  logic [3:0]  dbus_sel = 4'hF, mem_sel;
  logic        mem_cyc, mem_we, mem_ack = 1'b0;
  logic [AW-1:0] mem_adr;
  logic [31:0] mem_dat, mem_rdt = '0;

  wb_mem_arbiter #(.AW(AW), .IBUF_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_adr(dbus_adr), .dbus_dat(dbus_dat), .dbus_sel(dbus_sel), .dbus_we(dbus_we),
    .dbus_cyc(dbus_cyc), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .mem_cyc(mem_cyc), .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat(mem_dat),
    .mem_sel(mem_sel), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
  );

  // Second instance with the buffer disabled
  logic [31:0] n_ibus_adr = '0, n_ibus_rdt, n_dbus_rdt, n_mem_dat, n_mem_rdt = '0;
  logic        n_ibus_cyc = 1'b0, n_ibus_ack, n_dbus_ack, n_mem_cyc, n_mem_we, n_mem_ack = 1'b0;
  logic [AW-1:0] n_mem_adr;
  logic [3:0]  n_mem_sel;
  logic [31:0] n_zero32 = '0;
  logic [3:0]  n_zero4 = '0;
  logic        n_zero1 = 1'b0;

  wb_mem_arbiter #(.AW(AW), .IBUF_EN(1'b0)) u_dut_nobuf (
    .clk(clk), .rst(rst),
    .ibus_adr(n_ibus_adr), .ibus_cyc(n_ibus_cyc), .ibus_rdt(n_ibus_rdt), .ibus_ack(n_ibus_ack),
    .dbus_adr(n_zero32), .dbus_dat(n_zero32), .dbus_sel(n_zero4), .dbus_we(n_zero1),
    .dbus_cyc(n_zero1), .dbus_rdt(n_dbus_rdt), .dbus_ack(n_dbus_ack),
    .mem_cyc(n_mem_cyc), .mem_adr(n_mem_adr), .mem_we(n_mem_we), .mem_dat(n_mem_dat),
    .mem_sel(n_mem_sel), .mem_rdt(n_mem_rdt), .mem_ack(n_mem_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int inv_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory slave model: word array, default contents C0DE_xxxx, ack after mem_lat cycles.
  logic [31:0] marr [int];
  int          mem_lat = 3;
  int          mem_wait = 0;
  logic [31:0] mw;

  function automatic logic [31:0] mrd(input int a);
    if (marr.exists(a)) return marr[a];
    return 32'hC0DE0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    mem_rdt <= '0;
    if (mem_cyc && !mem_ack) begin
      if (mem_wait >= mem_lat) begin
        mem_ack  <= 1'b1;
        mem_wait <= 0;
        if (mem_we) begin
          mw = mrd(int'(mem_adr));
          for (int b = 0; b < 4; b++) if (mem_sel[b]) mw[8*b +: 8] = mem_dat[8*b +: 8];
          marr[int'(mem_adr)] = mw;
        end else begin
          mem_rdt <= mrd(int'(mem_adr));
        end
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else if (!mem_cyc) begin
      mem_wait <= 0;
    end
  end

  always @(posedge clk) begin
    n_mem_ack <= n_mem_cyc & ~n_mem_ack;
    n_mem_rdt <= (n_mem_cyc & ~n_mem_ack) ? 32'h0BADF00D : '0;
  end

  // Scoreboard and bus monitor
  typedef struct packed {
    logic        is_d;
    logic [31:0] rdt;
  } sb_t;
  sb_t sb_q [$];

  int            mem_reqs = 0, mem_gap = 100, n_reqs = 0;
  logic          prev_mem_cyc = 1'b0, prev_mem_ack = 1'b0, n_prev = 1'b0;
  logic [AW-1:0] cap_adr;
  logic          cap_we;
  logic [3:0]    cap_sel;
  logic [31:0]   cap_dat;

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      prev_mem_cyc = 1'b0;
      prev_mem_ack = 1'b0;
      mem_gap      = 100;
    end else begin
      if (ibus_ack && dbus_ack) inv_err++;
      if (!ibus_ack && ibus_rdt != 0) inv_err++;
      if (!dbus_ack && dbus_rdt != 0) inv_err++;
      if (prev_mem_ack && mem_cyc) inv_err++;
      if (ibus_ack || dbus_ack) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected ack: ibus_ack=%b dbus_ack=%b, expected no ack",
                   ibus_ack, dbus_ack);
        end else begin
          e = sb_q.pop_front();
          check("sb grantee", dbus_ack, e.is_d);
          check("sb rdata", dbus_ack ? dbus_rdt : ibus_rdt, e.rdt);
        end
      end
      if (mem_cyc && !prev_mem_cyc) begin
        mem_reqs++;
        if (mem_gap < 2) inv_err++;
        cap_adr = mem_adr; cap_we = mem_we; cap_sel = mem_sel; cap_dat = mem_dat;
      end else if (mem_cyc && {mem_adr, mem_we, mem_sel, mem_dat} !=
                              {cap_adr, cap_we, cap_sel, cap_dat}) begin
        inv_err++;
      end
      mem_gap      = mem_cyc ? 0 : mem_gap + 1;
      prev_mem_cyc = mem_cyc;
      prev_mem_ack = mem_ack;
    end
    if (n_mem_cyc && !n_prev) n_reqs++;
    n_prev = n_mem_cyc;
  end

  typedef struct {
    bit            is_d;
    logic [31:0]   adr;
    bit            we;
    logic [31:0]   dat;
    logic [3:0]    sel;
    int            lat;
    bit            exp_mem;
    logic [AW-1:0] exp_adr;
    logic [3:0]    exp_sel;
    logic [31:0]   exp_rdt;
  } vec_t;
  vec_t vecs [10];

  task automatic run_txn(input vec_t v, input string nm);
    int   reqs0, waited;
    bit   got, prev_mack;
    sb_t  e;
    @(posedge clk); #1;
    mem_lat  = v.lat;
    e.is_d   = v.is_d;
    e.rdt    = v.exp_rdt;
    sb_q.push_back(e);
    reqs0    = mem_reqs;
    if (v.is_d) begin
      dbus_adr = v.adr; dbus_we = v.we; dbus_dat = v.dat; dbus_sel = v.sel; dbus_cyc = 1'b1;
    end else begin
      ibus_adr = v.adr; ibus_cyc = 1'b1;
    end
    got = 1'b0; waited = 0; prev_mack = 1'b0;
    while (!got && waited < 300) begin
      @(negedge clk);
      waited++;
      got = v.is_d ? dbus_ack : ibus_ack;
      if (!got) prev_mack = mem_ack;
    end
    check({nm, " ack seen"}, got, 1'b1);
    if (!got) sb_q.delete();
    @(posedge clk); #1;
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    check({nm, " mem accesses"}, mem_reqs - reqs0, v.exp_mem ? 1 : 0);
    if (v.exp_mem) begin
      check({nm, " mem adr/we/sel"}, {cap_adr, cap_we, cap_sel}, {v.exp_adr, v.we, v.exp_sel});
      if (v.is_d) check({nm, " mem dat"}, cap_dat, v.dat);
      check({nm, " ack one cycle after mem_ack"}, prev_mack, 1'b1);
    end else begin
      check({nm, " hit latency"}, waited, 2);
    end
  endtask

  initial begin
    int  waited;
    bit  saw, dd, id;
    int  reqs0;
    sb_t e;
    vec_t v;

    //          is_d adr          we dat          sel   lat mem exp_adr  esel  exp_rdt
    vecs[0] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 60, 1'b1, 14'h040,  4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 3,  1'b0, 14'h000,  4'hF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h100,   1'b1, 32'h1234,  4'h3, 3,  1'b1, 14'h040,  4'h3, 32'h0};
    vecs[3] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 3,  1'b1, 14'h040,  4'hF, 32'hDEAD1234};
    vecs[4] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 3,  1'b0, 14'h000,  4'hF, 32'hDEAD1234};
    vecs[5] = '{1'b1, 32'h3FFFC, 1'b0, 32'h77,    4'hF, 4,  1'b1, 14'h3FFF, 4'hF, 32'hC0DE3FFF};
    vecs[6] = '{1'b1, 32'h100,   1'b0, 32'h0,     4'hF, 2,  1'b1, 14'h040,  4'hF, 32'hDEAD1234};
    vecs[7] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 3,  1'b0, 14'h000,  4'hF, 32'hDEAD1234};
    vecs[8] = '{1'b1, 32'h104,   1'b1, 32'h55,    4'hF, 3,  1'b1, 14'h041,  4'hF, 32'h0};
    vecs[9] = '{1'b0, 32'h100,   1'b0, 32'h0,     4'hF, 3,  1'b0, 14'h000,  4'hF, 32'hDEAD1234};
    marr[32'h40] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("reset mem ctl", {mem_cyc, mem_adr, mem_we, mem_sel, ibus_ack, dbus_ack}, '0);
    check("reset data", mem_dat | ibus_rdt | dbus_rdt, '0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: grants must alternate D, I, D, I
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      mem_lat = 3;
      reqs0 = mem_reqs;
      e.is_d = 1'b1; e.rdt = (r == 0) ? 32'hC0DE0180 : 32'hC0DE0181; sb_q.push_back(e);
      e.is_d = 1'b0; e.rdt = (r == 0) ? 32'hC0DE0080 : 32'hC0DE00C0; sb_q.push_back(e);
      ibus_adr = (r == 0) ? 32'h200 : 32'h300;
      dbus_adr = (r == 0) ? 32'h600 : 32'h604;
      dbus_we = 1'b0; dbus_sel = 4'hF;
      ibus_cyc = 1'b1; dbus_cyc = 1'b1;
      dd = 1'b0; id = 1'b0; waited = 0;
      while (!(dd && id) && waited < 200) begin
        @(negedge clk);
        waited++;
        if (dbus_ack) dd = 1'b1;
        if (ibus_ack) id = 1'b1;
        @(posedge clk); #1;
        if (dd) dbus_cyc = 1'b0;
        if (id) ibus_cyc = 1'b0;
      end
      check($sformatf("rr%0d both acked", r), {dd, id}, 2'b11);
      check($sformatf("rr%0d mem accesses", r), mem_reqs - reqs0, 2);
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
      sb_q.delete();
    end

    // Buffer now holds 0x300; reset in the middle of a data read must invalidate it
    v = '{1'b0, 32'h300, 1'b0, 32'h0, 4'hF, 3, 1'b0, 14'h0, 4'hF, 32'hC0DE00C0};
    run_txn(v, "pre-reset hit");
    @(posedge clk); #1;
    mem_lat = 20;
    dbus_adr = 32'h500; dbus_we = 1'b0; dbus_cyc = 1'b1;
    waited = 0;
    while (!mem_cyc && waited < 20) begin @(negedge clk); waited++; end
    check("rst: access started", mem_cyc, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst async mem ctl", {mem_cyc, mem_adr, mem_we, mem_sel, ibus_ack, dbus_ack}, '0);
    check("rst async data", mem_dat | ibus_rdt | dbus_rdt, '0);
    dbus_cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v = '{1'b0, 32'h300, 1'b0, 32'h0, 4'hF, 3, 1'b1, 14'h0C0, 4'hF, 32'hC0DE00C0};
    run_txn(v, "post-reset miss");

    // Requester gives up mid-access: access completes, ack suppressed
    @(posedge clk); #1;
    mem_lat = 5;
    ibus_adr = 32'h400; ibus_cyc = 1'b1;
    waited = 0;
    while (!mem_cyc && waited < 20) begin @(negedge clk); waited++; end
    @(posedge clk); #1;
    ibus_cyc = 1'b0;
    saw = 1'b0; waited = 0;
    while (mem_cyc && waited < 50) begin @(negedge clk); waited++; saw |= ibus_ack; end
    repeat (3) begin @(negedge clk); saw |= ibus_ack; end
    check("drop: access completed", mem_cyc, 1'b0);
    check("drop: ack suppressed", saw, 1'b0);

    // Buffer disabled: repeated fetch goes to memory both times
    reqs0 = n_reqs;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_ibus_adr = 32'h100; n_ibus_cyc = 1'b1;
      waited = 0;
      while (!n_ibus_ack && waited < 20) begin @(negedge clk); waited++; end
      check($sformatf("nobuf fetch%0d rdt", k), n_ibus_rdt, 32'h0BADF00D);
      @(posedge clk); #1;
      n_ibus_cyc = 1'b0;
    end
    check("nobuf mem accesses", n_reqs - reqs0, 2);

    repeat (3) @(negedge clk);
    check("pending scoreboard", sb_q.size(), 0);
    check("bus invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
